// File: rtl/fetch_stage_pkg.sv
// Shared fetch definitions: NOP encoding, instruction field positions,
// fetch FSM state encodings and the IF/ID entry layout.
package fetch_stage_pkg;

    // Instruction field bit positions (RV32 base encoding)
    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int F3_LSB  = 12;
    localparam int F3_MSB  = 14;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;
    localparam int F7_LSB  = 25;
    localparam int F7_MSB  = 31;

    // OP-IMM major opcode; NOP is addi x0,x0,0
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [31:0] NOP_INSTR = {12'd0, 5'd0, 3'b000, 5'd0, OP_IMM};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_entry_t;

    // Fetch addresses are always word aligned
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with load / hold / flush and field decode.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        load,
    input  logic        stall,
    input  if_entry_t   load_entry,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;

    // Flush beats load beats hold; an unstalled entry with nothing behind it is consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= 32'd0;
            instr_q <= NOP_INSTR;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            pc_q    <= load_entry.pc;
            instr_q <= load_entry.instr;
        end else if (!stall) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    // Dead entries present a NOP so the control unit never sees stale fields
    assign instr = valid_q ? instr_q : NOP_INSTR;

    assign opcode = instr[OPC_MSB:OPC_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];
    assign funct3 = instr[F3_MSB:F3_LSB];
    assign rs1    = instr[RS1_MSB:RS1_LSB];
    assign rs2    = instr[RS2_MSB:RS2_LSB];
    assign funct7 = instr[F7_MSB:F7_LSB];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: single-outstanding imem FSM, pc, one-entry skid buffer.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  kill_addr_q, kill_addr_d;
    logic [31:0]  skid_q, skid_d;
    logic         skid_vld_q, skid_vld_d;
    logic         req_q, req_d;
    logic         ifid_flush, ifid_load;
    if_entry_t    ifid_entry;
    logic [31:0]  tgt_pc;

    assign tgt_pc = word_align(redirect_pc);

    // Next-state, pc, skid and IF/ID control; redirect outranks stall and responses
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_addr_d = kill_addr_q;
        skid_d      = skid_q;
        skid_vld_d  = skid_vld_q;
        ifid_flush  = 1'b0;
        ifid_load   = 1'b0;
        ifid_entry.pc    = pc_q;
        ifid_entry.instr = imem_rdata;

        case (state_q)
            S_IDLE: begin
                // Any late response from before reset is simply ignored here
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    ifid_flush = 1'b1;
                    skid_vld_d = 1'b0;
                    pc_d       = tgt_pc;
                    if (!imem_valid) begin
                        // Request still in flight: keep its address until it returns
                        state_d     = S_DRAIN;
                        kill_addr_d = pc_q;
                    end
                end else if (imem_valid) begin
                    if (!stall || !if_id_valid) begin
                        ifid_load = 1'b1;
                        pc_d      = pc_q + 32'd4;
                    end else begin
                        skid_d     = imem_rdata;
                        skid_vld_d = 1'b1;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    ifid_flush = 1'b1;
                    skid_vld_d = 1'b0;
                    pc_d       = tgt_pc;
                    state_d    = S_FETCH;
                end else if (!stall && skid_vld_q) begin
                    ifid_load        = 1'b1;
                    ifid_entry.instr = skid_q;
                    pc_d             = pc_q + 32'd4;
                    skid_vld_d       = 1'b0;
                    state_d          = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    ifid_flush = 1'b1;
                    skid_vld_d = 1'b0;
                    pc_d       = tgt_pc;
                end
                if (imem_valid) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
    end

    // State, pc, skid and registered request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            kill_addr_q <= RESET_PC;
            skid_q      <= NOP_INSTR;
            skid_vld_q  <= 1'b0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_addr_q <= kill_addr_d;
            skid_q      <= skid_d;
            skid_vld_q  <= skid_vld_d;
            req_q       <= req_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = (state_q == S_DRAIN) ? kill_addr_q : pc_q;

    if_id_reg u_if_id (
        .clk        (clk),
        .rst        (rst),
        .flush      (ifid_flush),
        .load       (ifid_load),
        .stall      (stall),
        .load_entry (ifid_entry),
        .valid      (if_id_valid),
        .pc         (if_id_pc),
        .instr      (if_id_instr),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic against a
// transaction-level model of the fetch unit.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7),
        .rs1            (rs1),
        .rs2            (rs2),
        .rd             (rd)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: started after reset? request open? current request killed?
    bit          m_live, m_req, m_kill;
    logic [31:0] m_pc, m_kill_addr;
    logic [31:0] q_skid[$];
    bit          e_v;
    logic [31:0] e_pc, e_instr;

    function automatic void model_step(input bit r, input bit iv, input logic [31:0] rdata,
                                       input bit st, input bit rv, input logic [31:0] rp);
        bit loaded;
        loaded = 1'b0;
        if (r) begin
            m_live = 0; m_req = 0; m_kill = 0; m_pc = RESET_PC; m_kill_addr = RESET_PC;
            q_skid.delete();
            e_v = 0; e_pc = 32'd0; e_instr = NOP;
            return;
        end
        if (!m_live) begin
            m_live = 1; m_req = 1;
            return;
        end
        if (rv) begin
            // Everything younger than the branch dies; an in-flight fetch must still drain
            e_v = 0;
            q_skid.delete();
            if (!m_kill && m_req && !iv) begin
                m_kill = 1; m_kill_addr = m_pc;
            end else if (m_kill && iv) begin
                m_kill = 0;
            end
            m_pc  = rp & ~32'd3;
            m_req = 1;
            return;
        end
        if (m_kill) begin
            if (iv) m_kill = 0;
        end else if (q_skid.size() != 0) begin
            if (!st) begin
                e_v = 1; e_pc = m_pc; e_instr = q_skid.pop_front();
                m_pc = m_pc + 32'd4; m_req = 1; loaded = 1'b1;
            end
        end else if (iv) begin
            if (!st || !e_v) begin
                e_v = 1; e_pc = m_pc; e_instr = rdata;
                m_pc = m_pc + 32'd4; loaded = 1'b1;
            end else begin
                q_skid.push_back(rdata);
                m_req = 0;
            end
        end
        if (!loaded && !st) e_v = 0;
    endfunction

    task automatic compare_all();
        logic [31:0] ei;
        ei = e_v ? e_instr : NOP;
        chk("imem_req", 32'(imem_req), 32'(m_req));
        if (m_req)       chk("imem_addr", imem_addr, m_kill ? m_kill_addr : m_pc);
        else if (!m_live) chk("imem_addr_rst", imem_addr, RESET_PC);
        chk("if_id_valid", 32'(if_id_valid), 32'(e_v));
        if (e_v || !m_live) chk("if_id_pc", if_id_pc, e_pc);
        chk("if_id_instr", if_id_instr, ei);
        chk("opcode", 32'(opcode), ei & 32'h7f);
        chk("rd",     32'(rd),     (ei >> 7)  & 32'h1f);
        chk("funct3", 32'(funct3), (ei >> 12) & 32'h7);
        chk("rs1",    32'(rs1),    (ei >> 15) & 32'h1f);
        chk("rs2",    32'(rs2),    (ei >> 20) & 32'h1f);
        chk("funct7", 32'(funct7), ei >> 25);
    endtask

    // One clock: drive at the falling edge, advance model, check at the next falling edge
    task automatic cycle(input bit r, input bit iv, input logic [31:0] rdata,
                         input bit st, input bit rv, input logic [31:0] rp);
        rst = r; imem_valid = iv; imem_rdata = rdata; stall = st;
        redirect_valid = rv; redirect_pc = rp;
        model_step(r, iv, rdata, st, rv, rp);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [31:0] w[4];
        logic [31:0] w4;
        bit r, iv, st, rv;

        w[0] = 32'h0050_0093; w[1] = 32'h0020_8113; w[2] = 32'h4020_81B3; w[3] = 32'h0031_00B3;
        w4   = 32'h00A1_2023;

        rst = 1'b1; imem_valid = 1'b0; imem_rdata = 32'd0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'd0;
        model_step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);

        // Reset state
        cycle(1, 0, $urandom, 0, 0, 0);
        cycle(1, 0, $urandom, 0, 0, 0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_instr", if_id_instr, NOP);

        // Leave reset: request appears one cycle later at RESET_PC
        cycle(0, 0, $urandom, 0, 0, 0);
        chk("first_req", 32'(imem_req), 32'd1);

        // Back-to-back responses, no stall
        for (int i = 0; i < 4; i++) begin
            chk("stream_addr", imem_addr, 32'(4 * i));
            cycle(0, 1, w[i], 0, 0, 0);
            chk("stream_instr", if_id_instr, w[i]);
            chk("stream_pc", if_id_pc, 32'(4 * i));
        end

        // add x1,x2,x3 is now in IF/ID
        chk("add_opcode", 32'(opcode), 32'b0110011);
        chk("add_funct3", 32'(funct3), 32'd0);
        chk("add_funct7", 32'(funct7), 32'd0);
        chk("add_rd",     32'(rd),     32'd1);
        chk("add_rs1",    32'(rs1),    32'd2);
        chk("add_rs2",    32'(rs2),    32'd3);

        // Response while decode is stalled -> skid, request drops, IF/ID held
        cycle(0, 1, w4, 1, 0, 0);
        chk("hold_req", 32'(imem_req), 32'd0);
        chk("hold_instr", if_id_instr, w[3]);
        cycle(0, 0, $urandom, 1, 0, 0);
        cycle(0, 0, $urandom, 1, 0, 0);
        chk("hold_instr3", if_id_instr, w[3]);
        cycle(0, 0, $urandom, 0, 0, 0);
        chk("skid_instr", if_id_instr, w4);
        chk("skid_pc", if_id_pc, 32'h10);
        chk("skid_next_addr", imem_addr, 32'h14);

        // Redirect with request pending -> drain, late response dropped
        cycle(0, 0, $urandom, 0, 1, 32'h0000_0103);
        chk("drain_addr", imem_addr, 32'h14);
        cycle(0, 1, $urandom, 0, 0, 0);
        chk("drain_drop", 32'(if_id_valid), 32'd0);
        chk("redir_addr", imem_addr, 32'h100);

        // Redirect + stall + response in one cycle
        cycle(0, 1, w[0], 0, 0, 0);
        cycle(0, 1, $urandom, 1, 1, 32'h0000_0201);
        chk("flush_valid", 32'(if_id_valid), 32'd0);
        chk("flush_addr", imem_addr, 32'h200);

        // Reset while draining, then a late response
        cycle(0, 0, $urandom, 0, 1, 32'h0000_0300);
        cycle(1, 0, $urandom, 0, 0, 0);
        cycle(0, 1, $urandom, 0, 0, 0);
        chk("late_valid", 32'(if_id_valid), 32'd0);
        chk("post_rst_addr", imem_addr, RESET_PC);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 99) == 0);
            iv = (m_req || !m_live) ? bit'($urandom_range(0, 1)) : 1'b0;
            st = ($urandom_range(0, 2) == 0);
            rv = ($urandom_range(0, 9) == 0);
            cycle(r, iv, $urandom, st, rv, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
